// File: rtl/data_cache_pkg.sv
// Shared CPU-block parameters: default word/cache geometry, memory timing and
// the data-cache FSM state encoding.
package data_cache_pkg;

    localparam int DEFAULT_WORD_SIZE  = 32;
    localparam int DEFAULT_LINES      = 16;
    localparam int DEFAULT_INDEX_BITS = 4;

    // Nominal backing-memory read latency in cycles, mem_read to mem_valid.
    localparam int MEM_STALL = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2,
        ST_RESP   = 2'd3
    } cache_state_t;

endpackage

// File: rtl/data_cache_array.sv
// Direct-mapped valid/tag/data storage: one combinational read port, one
// synchronous write port. Only the valid bits are reset.
module cache_array
    import data_cache_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int LINES      = DEFAULT_LINES,
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
    parameter int TAG_BITS   = WORD_SIZE - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [WORD_SIZE-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [WORD_SIZE-1:0]  wr_data
);

    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tags  [LINES];
    logic [WORD_SIZE-1:0] words [LINES];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            words[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = words[rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through/no-allocate data cache
// serving a loader read port and a store-commit write port.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int LINES      = DEFAULT_LINES,
    parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_read_enable,
    input  logic [WORD_SIZE-1:0] c_ptr,
    output logic [WORD_SIZE-1:0] c_out,
    output logic                 c_hit,
    output logic                 c_done,
    input  logic                 w_enable,
    input  logic [WORD_SIZE-1:0] w_addr,
    input  logic [WORD_SIZE-1:0] w_data,
    output logic                 w_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_valid
);

    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

    cache_state_t          state, next_state;
    logic [WORD_SIZE-1:0]  req_addr;
    logic [WORD_SIZE-1:0]  look_addr;
    logic [INDEX_BITS-1:0] rd_index;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [WORD_SIZE-1:0]  rd_data;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_index;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [WORD_SIZE-1:0]  wr_data;
    logic                  line_hit;
    logic                  write_accept;
    logic                  fill_done;

    // The single read port serves the write-hit check in IDLE and the
    // latched read address everywhere else.
    assign look_addr    = (state == ST_IDLE) ? w_addr : req_addr;
    assign rd_index     = look_addr[INDEX_BITS-1:0];
    assign line_hit     = rd_valid && (rd_tag == look_addr[WORD_SIZE-1:INDEX_BITS]);
    assign w_ready      = (state == ST_IDLE) && !mem_read;
    assign write_accept = w_enable && w_ready;
    assign fill_done    = (state == ST_FILL) && mem_valid;

    cache_array #(
        .WORD_SIZE  (WORD_SIZE),
        .LINES      (LINES),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (rd_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    always_comb begin
        next_state = state;
        wr_en      = 1'b0;
        wr_index   = w_addr[INDEX_BITS-1:0];
        wr_tag     = w_addr[WORD_SIZE-1:INDEX_BITS];
        wr_data    = w_data;

        case (state)
            ST_IDLE: begin
                if (c_read_enable) begin
                    next_state = ST_LOOKUP;
                end
                // Write-through, no-allocate: only a resident line is refreshed.
                if (write_accept && line_hit && !reset) begin
                    wr_en = 1'b1;
                end
            end
            ST_LOOKUP: begin
                next_state = line_hit ? ST_RESP : ST_FILL;
            end
            ST_FILL: begin
                if (fill_done) begin
                    next_state = ST_RESP;
                    wr_en      = !reset;
                    wr_index   = req_addr[INDEX_BITS-1:0];
                    wr_tag     = req_addr[WORD_SIZE-1:INDEX_BITS];
                    wr_data    = mem_rdata;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr  <= '0;
            c_out     <= '0;
            c_hit     <= 1'b0;
            c_done    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            c_done    <= 1'b0;
            c_hit     <= 1'b0;
            mem_write <= write_accept;
            if (write_accept) begin
                mem_addr  <= w_addr;
                mem_wdata <= w_data;
            end

            case (state)
                ST_IDLE: begin
                    if (c_read_enable) begin
                        req_addr <= c_ptr;
                    end
                end
                ST_LOOKUP: begin
                    if (line_hit) begin
                        c_out  <= rd_data;
                        c_hit  <= 1'b1;
                        c_done <= 1'b1;
                    end else begin
                        mem_read <= 1'b1;
                        mem_addr <= req_addr;
                    end
                end
                ST_FILL: begin
                    if (mem_valid) begin
                        mem_read <= 1'b0;
                        c_out    <= mem_rdata;
                        c_done   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: hand-timed read/write sequences with
// immediate-assertion checks against hand-computed values.
module tb_data_cache;
    import data_cache_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         c_read_enable;
    logic [W-1:0] c_ptr;
    logic [W-1:0] c_out;
    logic         c_hit;
    logic         c_done;
    logic         w_enable;
    logic [W-1:0] w_addr;
    logic [W-1:0] w_data;
    logic         w_ready;
    logic         mem_read;
    logic         mem_write;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         mem_valid;

    int checks = 0;
    int errors = 0;

    data_cache #(.WORD_SIZE(W), .LINES(16), .INDEX_BITS(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .c_read_enable (c_read_enable),
        .c_ptr         (c_ptr),
        .c_out         (c_out),
        .c_hit         (c_hit),
        .c_done        (c_done),
        .w_enable      (w_enable),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .w_ready       (w_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_valid     (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One read transaction; for a miss, memory answers MEM_STALL cycles after mem_read rises.
    task automatic read_op(input string tag, input logic [W-1:0] addr, input logic exp_hit,
                           input logic [W-1:0] mem_word, input logic [W-1:0] exp_data);
        c_read_enable = 1'b1;
        c_ptr         = addr;
        tick();
        check({tag, "_lookup_done"}, W'(c_done), W'(0));
        tick();
        if (exp_hit) begin
            check({tag, "_hit_done"}, W'(c_done), W'(1));
            check({tag, "_hit_flag"}, W'(c_hit), W'(1));
            check({tag, "_hit_data"}, c_out, exp_data);
            check({tag, "_hit_noread"}, W'(mem_read), W'(0));
        end else begin
            check({tag, "_miss_nodone"}, W'(c_done), W'(0));
            check({tag, "_mem_read"}, W'(mem_read), W'(1));
            check({tag, "_mem_addr"}, mem_addr, addr);
            for (int i = 1; i < MEM_STALL; i++) tick();
            check({tag, "_mem_read_held"}, W'(mem_read), W'(1));
            mem_valid = 1'b1;
            mem_rdata = mem_word;
            tick();
            mem_valid = 1'b0;
            mem_rdata = '0;
            check({tag, "_miss_done"}, W'(c_done), W'(1));
            check({tag, "_miss_flag"}, W'(c_hit), W'(0));
            check({tag, "_miss_data"}, c_out, exp_data);
            check({tag, "_mem_read_drop"}, W'(mem_read), W'(0));
        end
        c_read_enable = 1'b0;
        tick();
        check({tag, "_done_pulse"}, W'(c_done), W'(0));
        check({tag, "_hit_low"}, W'(c_hit), W'(0));
    endtask

    task automatic write_op(input string tag, input logic [W-1:0] addr, input logic [W-1:0] data);
        check({tag, "_ready"}, W'(w_ready), W'(1));
        w_enable = 1'b1;
        w_addr   = addr;
        w_data   = data;
        tick();
        w_enable = 1'b0;
        check({tag, "_strobe"}, W'(mem_write), W'(1));
        check({tag, "_addr"}, mem_addr, addr);
        check({tag, "_wdata"}, mem_wdata, data);
        tick();
        check({tag, "_strobe_end"}, W'(mem_write), W'(0));
    endtask

    initial begin
        reset         = 1'b1;
        c_read_enable = 1'b0;
        c_ptr         = '0;
        w_enable      = 1'b0;
        w_addr        = '0;
        w_data        = '0;
        mem_rdata     = '0;
        mem_valid     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_c_done", W'(c_done), W'(0));
        check("rst_c_hit", W'(c_hit), W'(0));
        check("rst_c_out", c_out, W'(0));
        check("rst_mem_read", W'(mem_read), W'(0));
        check("rst_mem_write", W'(mem_write), W'(0));
        check("rst_mem_addr", mem_addr, W'(0));
        check("rst_mem_wdata", mem_wdata, W'(0));
        reset = 1'b0;
        tick();
        check("rst_w_ready", W'(w_ready), W'(1));

        // Cold miss then hit on 0x40
        read_op("r40_miss", 32'h40, 1'b0, 32'h1234, 32'h1234);
        read_op("r40_hit", 32'h40, 1'b1, 32'h0, 32'h1234);

        // Same-index conflict: 0x05 and 0x15 evict each other
        read_op("r05_fill", 32'h05, 1'b0, 32'hAA, 32'hAA);
        read_op("r15_conf", 32'h15, 1'b0, 32'hBB, 32'hBB);
        read_op("r05_again", 32'h05, 1'b0, 32'hAA, 32'hAA);

        // Write-through on a resident line, no-allocate on a non-resident one
        write_op("w40", 32'h40, 32'h9999);
        read_op("r40_updated", 32'h40, 1'b1, 32'h0, 32'h9999);
        write_op("w80", 32'h80, 32'h5555);
        read_op("r80_noalloc", 32'h80, 1'b0, 32'h6666, 32'h6666);

        // Same-cycle write and read of 0x40 once it is resident again
        read_op("r40_refill", 32'h40, 1'b0, 32'h9999, 32'h9999);
        w_enable      = 1'b1;
        w_addr        = 32'h40;
        w_data        = 32'h7;
        c_read_enable = 1'b1;
        c_ptr         = 32'h40;
        tick();
        w_enable = 1'b0;
        check("wr_rd_strobe", W'(mem_write), W'(1));
        check("wr_rd_addr", mem_addr, 32'h40);
        check("wr_rd_wdata", mem_wdata, 32'h7);
        tick();
        check("wr_rd_done", W'(c_done), W'(1));
        check("wr_rd_hit", W'(c_hit), W'(1));
        check("wr_rd_data", c_out, 32'h7);
        check("wr_rd_strobe_end", W'(mem_write), W'(0));
        c_read_enable = 1'b0;
        tick();

        // Write held across a fill is accepted exactly once, back in IDLE
        c_read_enable = 1'b1;
        c_ptr         = 32'h23;
        tick();
        w_enable = 1'b1;
        w_addr   = 32'h30;
        w_data   = 32'h31;
        check("hold_ready_lookup", W'(w_ready), W'(0));
        tick();
        check("hold_ready_fill", W'(w_ready), W'(0));
        check("hold_fill_read", W'(mem_read), W'(1));
        for (int i = 1; i < MEM_STALL; i++) tick();
        check("hold_no_strobe_fill", W'(mem_write), W'(0));
        mem_valid = 1'b1;
        mem_rdata = 32'h2323;
        tick();
        mem_valid = 1'b0;
        check("hold_resp_done", W'(c_done), W'(1));
        check("hold_resp_data", c_out, 32'h2323);
        check("hold_ready_resp", W'(w_ready), W'(0));
        check("hold_no_strobe_resp", W'(mem_write), W'(0));
        c_read_enable = 1'b0;
        tick();
        check("hold_ready_idle", W'(w_ready), W'(1));
        check("hold_not_yet", W'(mem_write), W'(0));
        tick();
        w_enable = 1'b0;
        check("hold_strobe", W'(mem_write), W'(1));
        check("hold_addr", mem_addr, 32'h30);
        check("hold_wdata", mem_wdata, 32'h31);
        tick();
        check("hold_once", W'(mem_write), W'(0));
        tick();
        check("hold_still_once", W'(mem_write), W'(0));

        // Reset during a fill; the late mem_valid must be ignored
        c_read_enable = 1'b1;
        c_ptr         = 32'h07;
        tick();
        tick();
        check("rf_fill_read", W'(mem_read), W'(1));
        reset         = 1'b1;
        c_read_enable = 1'b0;
        tick();
        reset = 1'b0;
        check("rf_read_cleared", W'(mem_read), W'(0));
        check("rf_addr_cleared", mem_addr, W'(0));
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD;
        tick();
        mem_valid = 1'b0;
        check("rf_late_valid_done", W'(c_done), W'(0));
        check("rf_w_ready", W'(w_ready), W'(1));
        tick();
        check("rf_late_valid_done2", W'(c_done), W'(0));
        read_op("rf_r07", 32'h07, 1'b0, 32'h77, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
